// File: rtl/fpga_rst_seq.sv
// Reset sequencer behind the PLL: debounces lock, releases NCH resets in staggered order,
// re-asserts everything on lock loss and supports a software-requested reset replay.
module fpga_rst_seq #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned STAGGER     = 16,
  parameter int unsigned SW_HOLD     = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_in,
  input  logic             areset,
  input  logic             pll_lock,
  input  logic             sw_rst_req,
  input  logic             lock_loss_clr,
  output logic [NCH-1:0]   srst,
  output logic             rst_done,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned MaxCnt = (LOCK_STABLE > STAGGER) ?
      ((LOCK_STABLE > SW_HOLD) ? LOCK_STABLE : SW_HOLD) :
      ((STAGGER > SW_HOLD) ? STAGGER : SW_HOLD);
  localparam int unsigned CW = $clog2(MaxCnt + 1);
  localparam int unsigned NW = $clog2(NCH + 1);

  // HOLD already consumed one qualified-lock cycle, so STABLE stops one short.
  localparam logic [CW-1:0] StableLast  = CW'((LOCK_STABLE >= 2) ? LOCK_STABLE - 2 : 0);
  localparam logic [CW-1:0] StaggerLast = CW'(STAGGER - 1);
  localparam logic [CW-1:0] SwHoldLast  = CW'(SW_HOLD - 1);
  localparam logic [NW-1:0] NchW        = NW'(NCH);

  typedef enum logic [2:0] {StHold, StStable, StRelease, StRun, StSwrst} state_e;

  // With a single channel the first release is also the last one.
  localparam state_e StFirst = (NCH == 1) ? StRun : StRelease;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NW-1:0]          nrel_q, nrel_d;
  logic [NCH-1:0]         srst_q, srst_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       llc_q, llc_d;
  logic                   lock_inc;
  logic                   rel_st;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nrel_d   = nrel_q;
    lock_inc = 1'b0;

    case (state_q)
      StHold: begin
        if (lock_s) begin
          cnt_d = '0;
          if (LOCK_STABLE == 1) begin
            state_d = StFirst;
            nrel_d  = NW'(1);
          end else begin
            state_d = StStable;
          end
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StFirst;
          cnt_d   = '0;
          nrel_d  = NW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StRelease, StRun: begin
        if (!lock_s) begin
          state_d  = StHold;
          cnt_d    = '0;
          nrel_d   = '0;
          lock_inc = 1'b1;
        end else if (sw_rst_req) begin
          state_d = StSwrst;
          cnt_d   = '0;
          nrel_d  = '0;
        end else if (state_q == StRelease) begin
          if (cnt_q == StaggerLast) begin
            cnt_d  = '0;
            nrel_d = nrel_q + NW'(1);
            if (nrel_d == NchW) state_d = StRun;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StSwrst: begin
        if (!lock_s) begin
          state_d  = StHold;
          cnt_d    = '0;
          lock_inc = 1'b1;
        end else if (cnt_q == SwHoldLast) begin
          state_d = StFirst;
          cnt_d   = '0;
          nrel_d  = NW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = StHold;
        cnt_d   = '0;
        nrel_d  = '0;
      end
    endcase

    rel_st = (state_d == StRelease) || (state_d == StRun);
    for (int unsigned i = 0; i < NCH; i++) begin
      srst_d[i] = ~(rel_st && (i < 32'(nrel_d)));
    end
    done_d = (state_d == StRun);

    llc_d = llc_q;
    if (lock_loss_clr) begin
      llc_d = lock_inc ? CNT_W'(1) : '0;
    end else if (lock_inc && (llc_q != '1)) begin
      llc_d = llc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      state_q <= StHold;
      cnt_q   <= '0;
      nrel_q  <= '0;
      srst_q  <= '1;
      done_q  <= 1'b0;
      llc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nrel_q  <= nrel_d;
      srst_q  <= srst_d;
      done_q  <= done_d;
      llc_q   <= llc_d;
    end
  end

  assign srst          = srst_q;
  assign rst_done      = done_q;
  assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Directed bench for fpga_rst_seq with NCH=4, SYNC_STAGES=3, LOCK_STABLE=8, STAGGER=4,
// SW_HOLD=5, CNT_W=2; edges are counted from the first edge after reset release.
module tb_fpga_rst_seq;

  logic       clk_in = 1'b0;
  logic       areset;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       lock_loss_clr;
  logic [3:0] srst;
  logic       rst_done;
  logic [1:0] lock_loss_cnt;

  int n_cmp  = 0;
  int n_bad  = 0;
  int k_edge = 0;

  always #5 clk_in = ~clk_in;

  fpga_rst_seq #(
    .NCH         (4),
    .SYNC_STAGES (3),
    .LOCK_STABLE (8),
    .STAGGER     (4),
    .SW_HOLD     (5),
    .CNT_W       (2)
  ) dut (
    .clk_in        (clk_in),
    .areset        (areset),
    .pll_lock      (pll_lock),
    .sw_rst_req    (sw_rst_req),
    .lock_loss_clr (lock_loss_clr),
    .srst          (srst),
    .rst_done      (rst_done),
    .lock_loss_cnt (lock_loss_cnt)
  );

  // Channel i falls at base + 4*i; all four are down at base + 12.
  function automatic logic [3:0] exp_srst(int k, int base);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (k < base + 4 * i);
    return r;
  endfunction

  function automatic logic exp_done(int k, int base);
    return (k >= base + 12);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
    k_edge++;
  endtask

  task automatic tick_n(int n);
    repeat (n) tick();
  endtask

  task automatic pulse_reset(logic lock_after);
    areset   = 1'b1;
    pll_lock = 1'b0;
    #2;
    areset   = 1'b0;
    pll_lock = lock_after;
    k_edge   = 0;
  endtask

  task automatic test_reset();
    areset        = 1'b0;
    pll_lock      = 1'b0;
    sw_rst_req    = 1'b0;
    lock_loss_clr = 1'b0;
    #1;
    areset = 1'b1;
    #2;
    n_cmp++;
    if (srst !== 4'hF || rst_done !== 1'b0 || lock_loss_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL reset: srst=%b done=%b cnt=%0d, want 1111 0 0", srst, rst_done,
               lock_loss_cnt);
    end
    tick();
  endtask

  task automatic test_power_up();
    areset   = 1'b0;
    pll_lock = 1'b1;
    k_edge   = 0;
    repeat (30) begin
      tick();
      n_cmp++;
      if (srst !== exp_srst(k_edge, 11) || rst_done !== exp_done(k_edge, 11)) begin
        n_bad++;
        $display("FAIL power_up edge %0d: srst=%b done=%b, want %b %b", k_edge, srst,
                 rst_done, exp_srst(k_edge, 11), exp_done(k_edge, 11));
      end
    end
    n_cmp++;
    if (lock_loss_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL power_up_cnt: cnt=%0d, want 0", lock_loss_cnt);
    end
  endtask

  task automatic test_sw_reset();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_cmp++;
    if (srst !== 4'hF || rst_done !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_assert edge %0d: srst=%b done=%b, want 1111 0", k_edge, srst,
               rst_done);
    end
    repeat (19) begin
      tick();
      n_cmp++;
      if (srst !== exp_srst(k_edge, 36) || rst_done !== exp_done(k_edge, 36)) begin
        n_bad++;
        $display("FAIL sw_release edge %0d: srst=%b done=%b, want %b %b", k_edge, srst,
                 rst_done, exp_srst(k_edge, 36), exp_done(k_edge, 36));
      end
    end
    n_cmp++;
    if (lock_loss_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL sw_cnt: cnt=%0d, want 0", lock_loss_cnt);
    end
  endtask

  task automatic test_lock_glitch();
    pulse_reset(1'b1);
    repeat (35) begin
      tick();
      if (k_edge == 7) pll_lock = 1'b0;
      if (k_edge == 10) pll_lock = 1'b1;
      n_cmp++;
      if (srst !== exp_srst(k_edge, 21) || rst_done !== exp_done(k_edge, 21)) begin
        n_bad++;
        $display("FAIL glitch edge %0d: srst=%b done=%b, want %b %b", k_edge, srst,
                 rst_done, exp_srst(k_edge, 21), exp_done(k_edge, 21));
      end
    end
    n_cmp++;
    if (lock_loss_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL glitch_cnt: cnt=%0d, want 0", lock_loss_cnt);
    end
  endtask

  task automatic test_lock_loss();
    logic [1:0] want;
    pll_lock = 1'b0;
    tick_n(3);
    n_cmp++;
    if (srst !== 4'h0 || rst_done !== 1'b1) begin
      n_bad++;
      $display("FAIL loss_before: srst=%b done=%b, want 0000 1", srst, rst_done);
    end
    lock_loss_clr = 1'b1;
    tick();
    lock_loss_clr = 1'b0;
    n_cmp++;
    if (srst !== 4'hF || rst_done !== 1'b0 || lock_loss_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL loss_clr_inc: srst=%b done=%b cnt=%0d, want 1111 0 1", srst, rst_done,
               lock_loss_cnt);
    end
    for (int r = 0; r < 5; r++) begin
      pll_lock = 1'b1;
      tick_n(14);
      n_cmp++;
      if (srst !== 4'b1110) begin
        n_bad++;
        $display("FAIL loss_relock %0d: srst=%b, want 1110", r, srst);
      end
      pll_lock = 1'b0;
      tick_n(5);
      want = (r == 0) ? 2'd2 : 2'd3;
      n_cmp++;
      if (srst !== 4'hF || lock_loss_cnt !== want) begin
        n_bad++;
        $display("FAIL loss_sat %0d: srst=%b cnt=%0d, want 1111 %0d", r, srst, lock_loss_cnt,
                 want);
      end
    end
    lock_loss_clr = 1'b1;
    tick();
    lock_loss_clr = 1'b0;
    n_cmp++;
    if (lock_loss_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL clr_alone: cnt=%0d, want 0", lock_loss_cnt);
    end
  endtask

  task automatic test_sw_vs_loss();
    pll_lock = 1'b1;
    tick_n(25);
    n_cmp++;
    if (srst !== 4'h0 || rst_done !== 1'b1) begin
      n_bad++;
      $display("FAIL sv_run: srst=%b done=%b, want 0000 1", srst, rst_done);
    end
    pll_lock = 1'b0;
    tick_n(3);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_cmp++;
    if (srst !== 4'hF || rst_done !== 1'b0 || lock_loss_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL sw_and_loss: srst=%b done=%b cnt=%0d, want 1111 0 1", srst, rst_done,
               lock_loss_cnt);
    end
    sw_rst_req = 1'b1;
    tick_n(8);
    sw_rst_req = 1'b0;
    n_cmp++;
    if (srst !== 4'hF || lock_loss_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL sw_in_hold: srst=%b cnt=%0d, want 1111 1", srst, lock_loss_cnt);
    end
    // Request lands while the FSM is qualifying lock and must not shift the schedule.
    pll_lock = 1'b1;
    k_edge   = 0;
    repeat (24) begin
      tick();
      sw_rst_req = (k_edge == 6);
      n_cmp++;
      if (srst !== exp_srst(k_edge, 11) || rst_done !== exp_done(k_edge, 11)) begin
        n_bad++;
        $display("FAIL sw_in_stable edge %0d: srst=%b done=%b, want %b %b", k_edge, srst,
                 rst_done, exp_srst(k_edge, 11), exp_done(k_edge, 11));
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_areset_mid();
    sw_rst_req = 1'b1;
    k_edge     = 24;
    tick();
    sw_rst_req = 1'b0;
    tick_n(10);
    n_cmp++;
    if (srst !== 4'b1100 || lock_loss_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL mid_release: srst=%b cnt=%0d, want 1100 1", srst, lock_loss_cnt);
    end
    areset = 1'b1;
    #1;
    n_cmp++;
    if (srst !== 4'hF || rst_done !== 1'b0 || lock_loss_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL async_reset: srst=%b done=%b cnt=%0d, want 1111 0 0", srst, rst_done,
               lock_loss_cnt);
    end
    #1;
    areset = 1'b0;
    k_edge = 0;
    repeat (24) begin
      tick();
      n_cmp++;
      if (srst !== exp_srst(k_edge, 11) || rst_done !== exp_done(k_edge, 11)) begin
        n_bad++;
        $display("FAIL requalify edge %0d: srst=%b done=%b, want %b %b", k_edge, srst,
                 rst_done, exp_srst(k_edge, 11), exp_done(k_edge, 11));
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_sw_reset();
    test_lock_glitch();
    test_lock_loss();
    test_sw_vs_loss();
    test_areset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
